// File: rtl/imem_boot_ctrl_if.sv
// Loader stream and instruction-memory load port of the boot sequencer.
// slave: the sequencer's side; master: the host/loader and processor side.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              init;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, init, init_addr, init_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, init, init_addr, init_data
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams words into instruction memory, then releases the core from reset.
// Optional BOOT_CHECKSUM_EN adds exp_sum and a wrap-around sum check before release.
module imem_boot_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
`ifdef BOOT_CHECKSUM_EN
  input  logic [DATA_W-1:0] exp_sum,
`endif
  imem_boot_ctrl_if.slave   ldr,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic              err_q, err_d;
  logic              init_q, init_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic [DATA_W-1:0] init_data_q, init_data_d;
  logic              accept;
  logic              sum_ok;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] exp_q, exp_d;
`endif

  assign accept = (state_q == LOAD) && ldr.s_valid;

`ifdef BOOT_CHECKSUM_EN
  assign sum_ok = (sum_q == exp_q);
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    err_d       = err_q;
    init_d      = 1'b0;
    init_addr_d = init_addr_q;
    init_data_d = init_data_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d       = sum_q;
    exp_d       = exp_q;
`endif

    // Write port is driven one cycle after the accept, even if the load is aborted.
    if (accept) begin
      init_d      = 1'b1;
      init_addr_d = addr_q[ADDR_W-1:0];
      init_data_d = ldr.s_data;
      addr_d      = addr_q + CNT_ONE;
`ifdef BOOT_CHECKSUM_EN
      sum_d       = sum_q + ldr.s_data;
`endif
    end

    case (state_q)
      IDLE, RUN: begin
        if ((state_q == RUN) && abort) begin
          state_d = IDLE;
        end else if (start) begin
          if (word_count > MAX_WORDS) begin
            err_d = 1'b1;
          end else begin
            err_d  = 1'b0;
            addr_d = '0;
            hold_d = '0;
            cnt_d  = word_count;
`ifdef BOOT_CHECKSUM_EN
            sum_d  = '0;
            exp_d  = exp_sum;
`endif
            state_d = (word_count == '0) ? HOLD : LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (accept && (addr_q == cnt_q - CNT_ONE)) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if (sum_ok) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
      init_q      <= 1'b0;
      init_addr_q <= '0;
      init_data_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= '0;
      exp_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      init_q      <= init_d;
      init_addr_q <= init_addr_d;
      init_data_q <= init_data_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
      exp_q       <= exp_d;
`endif
    end
  end

  assign ldr.s_ready   = (state_q == LOAD);
  assign ldr.init      = init_q;
  assign ldr.init_addr = init_addr_q;
  assign ldr.init_data = init_data_q;
  assign core_reset    = (state_q != RUN);
  assign busy          = (state_q == LOAD) || (state_q == HOLD);
  assign done          = (state_q == RUN);
  assign err           = err_q;

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer for the MIPS processor's instruction memory. Accepts a stream of instruction words over a valid/ready handshake and writes them into instruction memory through the processor's `init`/`init_addr`/`init_data` load port at sequential addresses from 0. Holds the core in reset during and after the load, then releases it. Sits between the host/loader link and the `MIPS_Processor` top.

## Interface

Parameters:
- `ADDR_W`, 8: instruction memory address width; max load = 2^ADDR_W words.
- `DATA_W`, 32: instruction word width.
- `HOLD_CYCLES`, 4: cycles `core_reset` stays high after the last write; legal range ≥ 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` input 1: begin load; sampled in IDLE and RUN only.
- `word_count` input ADDR_W+1: words to load; sampled with `start`.
- `abort` input 1: cancel load / halt core.
- `s_valid` input 1: loader word valid.
- `s_data` input DATA_W: loader word.
- `s_ready` output 1: block accepts a word this cycle.
- `init` output 1: instruction memory write strobe to the processor.
- `init_addr` output ADDR_W: write address.
- `init_data` output DATA_W: write data.
- `core_reset` output 1: active-high reset to the processor.
- `busy` output 1: high in LOAD or HOLD.
- `done` output 1: high in RUN.
- `err` output 1: sticky error flag; cleared by the next accepted `start`.

## Operation

- States: IDLE, LOAD, HOLD, RUN.
- Reset values: state IDLE, `init`=0, `init_addr`=0, `init_data`=0, `core_reset`=1, `s_ready`=0, `busy`=0, `done`=0, `err`=0. Address counter and hold counter are 0.
- IDLE
  - `core_reset`=1.
  - `start` with 1 ≤ `word_count` ≤ 2^ADDR_W: latch the count, set address counter to 0, clear `err`, go to LOAD.
  - `start` with `word_count`=0: go to HOLD; nothing is written.
  - `start` with `word_count` > 2^ADDR_W: set `err`=1 and stay in IDLE.
- LOAD
  - `s_ready`=1, decoded combinationally from state.
  - Each `s_valid && s_ready` cycle is one accept.
  - On the next cycle after an accept: `init`=1, `init_addr`=address counter, `init_data`=accepted word. The address counter then increments.
  - On the accept of word `word_count`-1, go to HOLD.
  - `abort`: go to IDLE, set `err`=1. A word accepted in the same cycle is still written. `abort` has priority over the state transition.
- HOLD
  - Hold counter counts HOLD_CYCLES cycles, then go to RUN.
  - `start` and `abort` are ignored.
- RUN
  - `core_reset`=0, `done`=1.
  - `start`: reload as from IDLE; `core_reset` reasserts on the next cycle.
  - `abort`: go to IDLE with `core_reset`=1; `err` is unchanged.
- `init` is a single-cycle pulse per word. It is never high outside the cycle that follows an accept.
- The address counter is ADDR_W+1 bits. Loading exactly 2^ADDR_W words writes addresses 0 through 2^ADDR_W-1, with no wrap-around.
- `init_addr`/`init_data` hold their last values when `init`=0.

## Timing

- Write latency: 1 cycle from accept to `init` pulse.
- Throughput: 1 word per cycle with `s_valid` held high.
- For an accept of the last word at cycle T:
  - Last `init` pulse at T+1.
  - State is HOLD at T+1.
  - `s_ready`=0 from T+1.
  - `core_reset` falls and `done` rises at T+1+HOLD_CYCLES.
- `start` in IDLE at cycle S: `busy` rises and `s_ready` rises at S+1.
- `reset` low mid-load: all outputs return to reset values at the next edge. Partial memory contents are left as-is.
- `s_valid` may drop at any time in LOAD; the FSM waits with no timeout.

## Configuration

- `BOOT_CHECKSUM_EN`
  - Defined:
    - Adds input `exp_sum` (DATA_W), latched with `start`.
    - Keeps a DATA_W-bit wrap-around sum of accepted words, cleared on `start`.
    - On the HOLD→RUN transition, a mismatch sets `err`=1 and goes to IDLE with `core_reset` held at 1.
    - A `word_count`=0 load expects `exp_sum`=0.
  - Undefined: no `exp_sum` port and no summing logic; HOLD always proceeds to RUN.

## Test plan

- Reset, then `start` with `word_count`=3 and words 0x8C010004, 0xAC020008, 0x2001000A streamed back-to-back.
  - Required: `init` pulses at addr 0, 1, 2 on consecutive cycles with matching data.
  - Required: `core_reset` falls 4 cycles after the last pulse; `done`=1.
- `s_valid` toggling every other cycle, `word_count`=2 → exactly 2 `init` pulses, addresses 0 and 1, each one cycle after its accept.
- `abort` after 1 of 3 words → 1 write, IDLE, `err`=1, `core_reset`=1. A following `start` clears `err`.
- `word_count`=0 → no `init` pulse; `core_reset` falls 1+HOLD_CYCLES cycles after `start`.
- `word_count`=2^ADDR_W+1 → `err`=1, stays IDLE, `s_ready`=0. Separately, `word_count`=256 (ADDR_W=8) writes addresses 0 through 255 with no wrap.
- `BOOT_CHECKSUM_EN`:
  - Words 1, 2, 3 with `exp_sum`=6 → RUN.
  - Same words with `exp_sum`=7 → `err`=1, IDLE, `core_reset`=1.
  - `reset` low mid-load → all outputs return to reset values.
